serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial N-bit adder built around the team's 1-bit full-adder cell. It captures two N-bit operands and a carry-in on a start request, then presents one operand bit pair per cycle, LSB first, to a single full-adder cell. A registered carry closes the loop from one bit to the next. The block reassembles the sum bits into a parallel result. It sits directly upstream of the full-adder cell: it feeds that cell and consumes what the cell produces.

## Interface
Parameters:
- NUM_BITS, 8, operand/result width; legal range 2–32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition; sampled on clk.
- a  input  NUM_BITS  operand A; sampled only on an accepted start.
- b  input  NUM_BITS  operand B; sampled only on an accepted start.
- carry_in  input  1  initial carry; sampled only on an accepted start.
- sum  output  NUM_BITS  registered result; holds until the next completion.
- carry_out  output  1  registered carry out of the MSB.
- overflow  output  1  registered signed overflow (see Configuration).
- busy  output  1  high while an addition is in progress (ADD state).
- done  output  1  one-cycle completion pulse (DONE state).

Reset state: sum=0, carry_out=0, overflow=0, busy=0, done=0, FSM=IDLE, internal shift and count registers 0.

## Operation
- FSM states are IDLE, ADD and DONE. The outputs are Moore outputs: busy=(state==ADD), done=(state==DONE).
- IDLE or DONE with start=1 → ADD. On that edge:
  - opA←a and opB←b (internal shift registers);
  - c_reg←carry_in;
  - cnt←0.
- IDLE or DONE with start=0 → IDLE.
- ADD, every cycle:
  - Drive the full-adder cell with opA[0], opB[0] and c_reg. The cell computes s=opA[0]^opB[0]^c_reg and co=majority(opA[0],opB[0],c_reg).
  - At the edge: res←{s, res[NUM_BITS-1:1]}; opA and opB shift right by 1 with zero fill; c_reg←co; cnt←cnt+1.
  - The cell's carry-in for the MSB bit is latched as c_msb when cnt==NUM_BITS-1.
- ADD with cnt==NUM_BITS-1 → DONE. On that edge:
  - sum←{s, res[NUM_BITS-1:1]};
  - carry_out←co;
  - overflow←co^c_msb (when enabled).
- start is ignored while in ADD. It does not restart or extend the operation.
- The cnt width is $clog2(NUM_BITS). cnt never wraps within one operation.
- sum, carry_out and overflow change only on the edge entering DONE, or on reset. They are stable in IDLE and ADD.
- Simulation-only checks in an always block raise $error in these cases:
  - start is not 0/1 at any edge;
  - a, b or carry_in contain X/Z when start is accepted.

## Timing
- Let edge T0 be the edge where start=1 is sampled in IDLE or DONE. busy is high for cycles T0..T0+NUM_BITS-1, i.e. NUM_BITS cycles.
- done is high for exactly one cycle, after edge T0+NUM_BITS. The results are valid in that same cycle.
- Total latency from the start edge to done is NUM_BITS cycles.
- Back-to-back throughput: start may be held high or reasserted during DONE. The next ADD then begins at the edge leaving DONE, so one result is produced every NUM_BITS+1 cycles.
- Asynchronous reset at any point, including mid-ADD, forces the reset state immediately. The partial result is discarded and done is not pulsed. After n_rst rises, the first edge with start=1 begins a fresh operation.

## Configuration
- SERIAL_ADDER_OVERFLOW_EN
  - Defined: the c_msb capture register and the overflow flop are compiled in. overflow=co^c_msb of the final bit (two's-complement overflow) and holds with sum.
  - Undefined: no c_msb register is built. overflow is tied to constant 0. The port list is unchanged.

## Test plan
All scenarios use NUM_BITS=8.
1. Reset with n_rst=0, then release → all outputs 0, busy=0, done=0. Then start with a=8'h0F, b=8'h01, cin=0 → busy for 8 cycles; done pulses exactly 8 cycles after the start edge; sum=8'h10, carry_out=0, overflow=0.
2. a=8'hFF, b=8'h01, cin=0 → sum=8'h00, carry_out=1, overflow=0. Then a=8'h00, b=8'h00, cin=1 → sum=8'h01, carry_out=0.
3. a=8'h7F, b=8'h01, cin=0 → sum=8'h80, carry_out=0. overflow=1 with SERIAL_ADDER_OVERFLOW_EN defined, 0 without. Also a=8'h80, b=8'h80 → sum=8'h00, carry_out=1, overflow=1 (enabled).
4. Start with a=8'h12, b=8'h34. Pulse start again with different operands at ADD cycle 3 → ignored; done still arrives at T0+8 with sum=8'h46. sum holds 8'h46 through the following IDLE cycles.
5. Start with a=8'hAA, b=8'h55. Assert n_rst=0 mid-ADD at cycle 4 → outputs clear immediately and no done pulse follows. After release, a=8'h01, b=8'h02 → sum=8'h03 at T0+8.
6. Hold start high continuously with a=8'h10, b=8'h20 → done pulses every 9 cycles and sum=8'h30 each time. Also run 1000 random a/b/cin triples, comparing {carry_out,sum} against a+b+cin.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit adder wrapped around a 1-bit full-adder cell.
//
// On an accepted start the operands and carry-in are captured, then one bit
// pair per cycle (LSB first) is fed to the full-adder cell. A registered
// carry links consecutive bits, and the sum bits are shifted into a result
// register that is copied to the parallel outputs on completion.
//
// Optional feature macro: SERIAL_ADDER_OVERFLOW_EN
//   defined   - carry-into-MSB capture and a registered two's-complement
//               overflow flag are built; overflow holds alongside sum.
//   undefined - no capture register; overflow is tied to 0.
//
// Handshake: start is a level request sampled on every rising edge. It is
// accepted only in IDLE or DONE. The result (sum/carry_out/overflow) is valid
// in the single cycle that done is high and holds until the next completion.
// start seen during ADD is ignored; it neither restarts nor extends the add.

// One-bit full-adder cell: sum and majority carry.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module serial_adder #(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    output logic [NUM_BITS-1:0] sum,
    output logic                carry_out,
    output logic                overflow,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W = $clog2(NUM_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // fsm_state is the observable state for checkers bound to this block.
    state_t fsm_state;
    state_t state_next;

    logic [NUM_BITS-1:0] op_a;
    logic [NUM_BITS-1:0] op_b;
    logic [NUM_BITS-1:0] res;
    logic [NUM_BITS-1:0] res_next;
    logic [CNT_W-1:0]    cnt;
    logic                c_reg;
    logic                sum_bit;
    logic                carry_bit;
    logic                accept;
    logic                last_bit;

    // A request is honoured only when no addition is in flight.
    assign accept   = start && (fsm_state != ST_ADD);
    assign last_bit = (fsm_state == ST_ADD) && (cnt == CNT_LAST);

    // The cell always sees the current LSB pair and the running carry.
    full_adder_cell u_cell (
        .a  (op_a[0]),
        .b  (op_b[0]),
        .ci (c_reg),
        .s  (sum_bit),
        .co (carry_bit)
    );

    // New sum bit enters at the MSB so the LSB ends up at bit 0 after N shifts.
    assign res_next = {sum_bit, res[NUM_BITS-1:1]};

    // Moore status outputs.
    assign busy = (fsm_state == ST_ADD);
    assign done = (fsm_state == ST_DONE);

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fsm_state <= ST_IDLE;
        end else begin
            fsm_state <= state_next;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_next = fsm_state;
        case (fsm_state)
            ST_IDLE: begin
                if (start) state_next = ST_ADD;
                else       state_next = ST_IDLE;
            end
            ST_ADD: begin
                if (cnt == CNT_LAST) state_next = ST_DONE;
                else                 state_next = ST_ADD;
            end
            ST_DONE: begin
                if (start) state_next = ST_ADD;
                else       state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand shift registers, running carry and bit counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            op_a  <= '0;
            op_b  <= '0;
            c_reg <= 1'b0;
            cnt   <= '0;
            res   <= '0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= b;
            c_reg <= carry_in;
            cnt   <= '0;
        end else if (fsm_state == ST_ADD) begin
            op_a  <= {1'b0, op_a[NUM_BITS-1:1]};
            op_b  <= {1'b0, op_b[NUM_BITS-1:1]};
            c_reg <= carry_bit;
            res   <= res_next;
            // Counter parks at zero on the final bit instead of wrapping.
            if (last_bit) cnt <= '0;
            else          cnt <= cnt + CNT_W'(1);
        end
    end

    // Parallel result registers, updated only on the edge entering DONE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (last_bit) begin
            sum       <= res_next;
            carry_out <= carry_bit;
        end
    end

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic c_msb;
    logic c_msb_d;
    logic overflow_q;

    // Carry into the MSB is the running carry while the last bit is processed.
    assign c_msb_d = last_bit ? c_reg : c_msb;

    // Capture carry-into-MSB and derive signed overflow on completion.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            c_msb      <= 1'b0;
            overflow_q <= 1'b0;
        end else if (last_bit) begin
            c_msb      <= c_msb_d;
            overflow_q <= carry_bit ^ c_msb_d;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

`ifndef SYNTHESIS
    // Simulation guard against undefined control and unknown captured operands.
    always @(posedge clk) begin
        if (n_rst) begin
            if ($isunknown(start)) begin
                $error("serial_adder: start is not 0/1");
            end else if (accept && ($isunknown(a) || $isunknown(b) || $isunknown(carry_in))) begin
                $error("serial_adder: unknown operand on accepted start");
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (NUM_BITS=8). Reference results come from plain
// integer arithmetic on the operands; overflow expectations follow the
// SERIAL_ADDER_OVERFLOW_EN build option.
module tb_serial_adder;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         carry_in = 1'b0;
    logic [N-1:0] sum;
    logic         carry_out;
    logic         overflow;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [N:0] exp_q[$];

    // Directed arithmetic vectors with expected results.
    logic [N-1:0] vec_a   [4] = '{8'hFF, 8'h00, 8'h7F, 8'h80};
    logic [N-1:0] vec_b   [4] = '{8'h01, 8'h00, 8'h01, 8'h80};
    logic         vec_ci  [4] = '{1'b0,  1'b1,  1'b0,  1'b0};
    logic [N-1:0] vec_sum [4] = '{8'h00, 8'h01, 8'h80, 8'h00};
    logic         vec_co  [4] = '{1'b1,  1'b0,  1'b0,  1'b1};
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic         vec_ov  [4] = '{1'b0,  1'b0,  1'b1,  1'b1};
`else
    logic         vec_ov  [4] = '{1'b0,  1'b0,  1'b0,  1'b0};
`endif

    serial_adder #(.NUM_BITS(N)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done)
    );

    // Clock and reset block.
    always #5 clk = ~clk;

    // Reference: unsigned add giving {carry, sum}.
    function automatic logic [N:0] ref_add(logic [N-1:0] x, logic [N-1:0] y, logic ci);
        int s;
        s = int'(x) + int'(y) + int'(ci);
        return (N+1)'(s);
    endfunction

    // Reference: signed result outside the N-bit two's-complement range.
    function automatic logic ref_ovf(logic [N-1:0] x, logic [N-1:0] y, logic ci);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        int s;
        s = int'($signed(x)) + int'($signed(y)) + int'(ci);
        return (s > (2**(N-1) - 1)) || (s < -(2**(N-1)));
`else
        return 1'b0;
`endif
    endfunction

    // Driver: present a one-cycle start; leaves time at #1 after the start edge.
    task automatic drive_start(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci);
        start    = 1'b1;
        a        = x;
        b        = y;
        carry_in = ci;
        @(posedge clk);
        #1;
        start    = 1'b0;
        a        = N'($urandom);
        b        = N'($urandom);
        carry_in = 1'($urandom_range(0, 1));
    endtask

    // Driver: count edges from the start edge until done, bounded.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (!done && lat < 50) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({sum, carry_out, overflow, busy, done} !== '0)
            $display("FAIL reset_held got sum=%h co=%b ov=%b busy=%b done=%b exp all 0", sum, carry_out, overflow, busy, done);
        else n_pass++;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({sum, carry_out, overflow, busy, done} !== '0)
            $display("FAIL reset_release got sum=%h co=%b ov=%b busy=%b done=%b exp all 0", sum, carry_out, overflow, busy, done);
        else n_pass++;
    endtask

    task automatic test_basic();
        int lat;
        bit bok;
        drive_start(8'h0F, 8'h01, 1'b0);
        wait_done(lat, bok);
        n_checks++;
        if (lat !== 8) $display("FAIL basic_latency got %0d exp 8", lat); else n_pass++;
        n_checks++;
        if (bok !== 1'b1) $display("FAIL basic_busy got busy low during add exp high"); else n_pass++;
        n_checks++;
        if ({carry_out, sum} !== 9'h010) $display("FAIL basic_sum got %b_%h exp 0_10", carry_out, sum); else n_pass++;
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL basic_ovf got %b exp 0", overflow); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if ({done, busy} !== 2'b00) $display("FAIL basic_done_pulse got done=%b busy=%b exp 0 0", done, busy); else n_pass++;
    endtask

    task automatic test_arith();
        int lat;
        bit bok;
        for (int i = 0; i < 4; i++) begin
            drive_start(vec_a[i], vec_b[i], vec_ci[i]);
            wait_done(lat, bok);
            n_checks++;
            if (lat !== 8 || bok !== 1'b1) $display("FAIL arith%0d_timing got lat=%0d busy_ok=%b exp 8 1", i, lat, bok); else n_pass++;
            n_checks++;
            if (sum !== vec_sum[i]) $display("FAIL arith%0d_sum got %h exp %h", i, sum, vec_sum[i]); else n_pass++;
            n_checks++;
            if (carry_out !== vec_co[i]) $display("FAIL arith%0d_cout got %b exp %b", i, carry_out, vec_co[i]); else n_pass++;
            n_checks++;
            if (overflow !== vec_ov[i]) $display("FAIL arith%0d_ovf got %b exp %b", i, overflow, vec_ov[i]); else n_pass++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        drive_start(8'h12, 8'h34, 1'b0);
        lat = 0;
        while (!done && lat < 50) begin
            if (lat == 3) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hEE;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        n_checks++;
        if (lat !== 8) $display("FAIL ignore_latency got %0d exp 8", lat); else n_pass++;
        n_checks++;
        if ({carry_out, sum} !== 9'h046) $display("FAIL ignore_sum got %b_%h exp 0_46", carry_out, sum); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (sum !== 8'h46 || done !== 1'b0 || busy !== 1'b0)
                $display("FAIL ignore_hold%0d got sum=%h done=%b busy=%b exp 46 0 0", i, sum, done, busy);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit bok;
        bit seen_done;
        drive_start(8'hAA, 8'h55, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        n_checks++;
        if ({sum, carry_out, overflow, busy, done} !== '0)
            $display("FAIL midreset_clear got sum=%h co=%b ov=%b busy=%b done=%b exp all 0", sum, carry_out, overflow, busy, done);
        else n_pass++;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done !== 1'b0) $display("FAIL midreset_no_done got activity=1 exp 0"); else n_pass++;
        drive_start(8'h01, 8'h02, 1'b0);
        wait_done(lat, bok);
        n_checks++;
        if (lat !== 8) $display("FAIL midreset_latency got %0d exp 8", lat); else n_pass++;
        n_checks++;
        if ({carry_out, sum} !== 9'h003) $display("FAIL midreset_sum got %b_%h exp 0_03", carry_out, sum); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int k;
        int last;
        int pulses;
        start    = 1'b1;
        a        = 8'h10;
        b        = 8'h20;
        carry_in = 1'b0;
        @(posedge clk);
        #1;
        k      = 0;
        last   = 0;
        pulses = 0;
        while (pulses < 3 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
            if (done) begin
                n_checks++;
                if (k - last !== ((pulses == 0) ? 8 : 9))
                    $display("FAIL b2b_interval%0d got %0d exp %0d", pulses, k - last, (pulses == 0) ? 8 : 9);
                else n_pass++;
                n_checks++;
                if ({carry_out, sum} !== 9'h030) $display("FAIL b2b_sum%0d got %b_%h exp 0_30", pulses, carry_out, sum); else n_pass++;
                last = k;
                pulses++;
            end
        end
        start = 1'b0;
        n_checks++;
        if (pulses !== 3) $display("FAIL b2b_pulses got %0d exp 3", pulses); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done} !== 2'b00) $display("FAIL b2b_idle got busy=%b done=%b exp 0 0", busy, done); else n_pass++;
    endtask

    task automatic test_random();
        int lat;
        bit bok;
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic ci;
        logic [N:0] exp_v;
        logic exp_o;
        for (int i = 0; i < 1000; i++) begin
            x  = N'($urandom);
            y  = N'($urandom);
            ci = 1'($urandom_range(0, 1));
            exp_q.push_back(ref_add(x, y, ci));
            exp_o = ref_ovf(x, y, ci);
            drive_start(x, y, ci);
            wait_done(lat, bok);
            n_checks++;
            if (lat !== 8 || bok !== 1'b1) $display("FAIL rand%0d_timing got lat=%0d busy_ok=%b exp 8 1", i, lat, bok); else n_pass++;
            exp_v = exp_q.pop_front();
            n_checks++;
            if ({carry_out, sum} !== exp_v)
                $display("FAIL rand%0d_sum a=%h b=%h ci=%b got %h exp %h", i, x, y, ci, {carry_out, sum}, exp_v);
            else n_pass++;
            n_checks++;
            if (overflow !== exp_o) $display("FAIL rand%0d_ovf got %b exp %b", i, overflow, exp_o); else n_pass++;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arith();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
